// File: rtl/decode_execute_reg_if.sv
// ID -> EX boundary signals of the RV32I pipeline: decoded-side inputs, WB bypass,
// flush/stall handshake and the registered EX-side outputs.
interface decode_execute_reg_if #(parameter int CNT_W = 16);
  logic [31:0]      InstrD;
  logic [31:0]      PCD;
  logic [31:0]      PCPlus4D;
  logic             ValidD;
  logic [31:0]      RD1D;
  logic [31:0]      RD2D;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [31:0]      ResultW;
  logic             FlushE;
  logic             StallD;
  logic             ValidE;
  logic             RegWriteE;
  logic             IsLoadE;
  logic [6:0]       OpcodeE;
  logic [2:0]       Funct3E;
  logic             Funct7b5E;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [31:0]      RD1E;
  logic [31:0]      RD2E;
  logic [31:0]      ImmExtE;
  logic [31:0]      PCE;
  logic [31:0]      PCPlus4E;
  logic [CNT_W-1:0] BubbleCnt;

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, RD1D, RD2D, RegWriteW, RdW, ResultW, FlushE,
    input  StallD, ValidE, RegWriteE, IsLoadE, OpcodeE, Funct3E, Funct7b5E, Rs1E, Rs2E, RdE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, BubbleCnt
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, RD1D, RD2D, RegWriteW, RdW, ResultW, FlushE,
    output StallD, ValidE, RegWriteE, IsLoadE, OpcodeE, Funct3E, Funct7b5E, Rs1E, Rs2E, RdE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, BubbleCnt
  );
endinterface

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: immediate generation, WB->ID operand bypass,
// load-use bubble insertion with a saturating bubble counter.
module decode_execute_reg #(
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  decode_execute_reg_if.slave dx
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] instr;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] imm;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        reg_write_d;
  logic        is_load_d;
  logic        hazard;
  logic        count_en;
  logic [0:0]  state_reg;
  logic [0:0]  state_next;
  logic [CNT_W-1:0] bubble_cnt_reg;

  assign instr  = dx.InstrD;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Register file writes at the same edge it is read for ID, so forward WB data here.
  assign op1 = (dx.RegWriteW && dx.RdW != 5'd0 && dx.RdW == rs1) ? dx.ResultW : dx.RD1D;
  assign op2 = (dx.RegWriteW && dx.RdW != 5'd0 && dx.RdW == rs2) ? dx.ResultW : dx.RD2D;

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_S:                   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_B:                   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm = {instr[31:12], 12'd0};
      OP_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                imm = 32'd0;
    endcase
  end

  assign uses_rs1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                    (opcode == OP_S) || (opcode == OP_B) || (opcode == OP_JALR);
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);

  assign reg_write_d = dx.ValidD && (rd != 5'd0) &&
                       ((opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                        (opcode == OP_JALR) || (opcode == OP_JAL) || (opcode == OP_LUI) ||
                        (opcode == OP_AUIPC));
  assign is_load_d   = dx.ValidD && (opcode == OP_LOAD);

  assign hazard = dx.ValidD && dx.ValidE && dx.IsLoadE && (dx.RdE != 5'd0) &&
                  ((uses_rs1 && rs1 == dx.RdE) || (uses_rs2 && rs2 == dx.RdE));

  // A flush squashes ID too, so no stall is needed when both coincide.
  assign dx.StallD = hazard && !dx.FlushE;
  assign count_en  = (state_reg == ST_RUN) && hazard && !dx.FlushE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (hazard && !dx.FlushE) state_next = ST_BUBBLE;
      ST_BUBBLE: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  assign dx.BubbleCnt = bubble_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_RUN;
      bubble_cnt_reg <= '0;
      dx.ValidE      <= 1'b0;
      dx.RegWriteE   <= 1'b0;
      dx.IsLoadE     <= 1'b0;
      dx.OpcodeE     <= 7'd0;
      dx.Funct3E     <= 3'd0;
      dx.Funct7b5E   <= 1'b0;
      dx.Rs1E        <= 5'd0;
      dx.Rs2E        <= 5'd0;
      dx.RdE         <= 5'd0;
      dx.RD1E        <= 32'd0;
      dx.RD2E        <= 32'd0;
      dx.ImmExtE     <= 32'd0;
      dx.PCE         <= 32'd0;
      dx.PCPlus4E    <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (count_en && bubble_cnt_reg != {CNT_W{1'b1}})
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      if (dx.FlushE || hazard) begin
        dx.ValidE    <= 1'b0;
        dx.RegWriteE <= 1'b0;
        dx.IsLoadE   <= 1'b0;
        dx.OpcodeE   <= 7'd0;
        dx.Funct3E   <= 3'd0;
        dx.Funct7b5E <= 1'b0;
        dx.Rs1E      <= 5'd0;
        dx.Rs2E      <= 5'd0;
        dx.RdE       <= 5'd0;
        dx.RD1E      <= 32'd0;
        dx.RD2E      <= 32'd0;
        dx.ImmExtE   <= 32'd0;
        dx.PCE       <= 32'd0;
        dx.PCPlus4E  <= 32'd0;
      end else begin
        dx.ValidE    <= dx.ValidD;
        dx.RegWriteE <= reg_write_d;
        dx.IsLoadE   <= is_load_d;
        dx.OpcodeE   <= opcode;
        dx.Funct3E   <= instr[14:12];
        dx.Funct7b5E <= instr[30];
        dx.Rs1E      <= rs1;
        dx.Rs2E      <= rs2;
        dx.RdE       <= rd;
        dx.RD1E      <= op1;
        dx.RD2E      <= op2;
        dx.ImmExtE   <= imm;
        dx.PCE       <= dx.PCD;
        dx.PCPlus4E  <= dx.PCPlus4D;
      end
    end
  end
endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: instruction-level model checked every negedge,
// plus hand-computed expectations for immediates, bypass, load-use, flush and saturation.
module tb_decode_execute_reg;
  logic clk;
  logic rst;
  logic chk_en;
  int   total;
  int   bad;

  decode_execute_reg_if #(.CNT_W(16)) if1 ();
  decode_execute_reg_if #(.CNT_W(2))  if2 ();

  decode_execute_reg #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .dx(if1));
  decode_execute_reg #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .dx(if2));

  assign if2.InstrD    = if1.InstrD;
  assign if2.PCD       = if1.PCD;
  assign if2.PCPlus4D  = if1.PCPlus4D;
  assign if2.ValidD    = if1.ValidD;
  assign if2.RD1D      = if1.RD1D;
  assign if2.RD2D      = if1.RD2D;
  assign if2.RegWriteW = if1.RegWriteW;
  assign if2.RdW       = if1.RdW;
  assign if2.ResultW   = if1.ResultW;
  assign if2.FlushE    = if1.FlushE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic        m_valid, m_regwrite, m_isload, m_f7;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  int          m_bubbles;

  function automatic byte fmt(input logic [31:0] i);
    case (i[6:0])
      7'b0110011:                                return "R";
      7'b0010011, 7'b1100111:                    return "I";
      7'b0000011:                                return "L";
      7'b0100011:                                return "S";
      7'b1100011:                                return "B";
      7'b0110111, 7'b0010111:                    return "U";
      7'b1101111:                                return "J";
      default:                                   return "X";
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (fmt(i))
      "I", "L": v = int'($signed(i) >>> 20);
      "S":      v = int'(($signed(i) >>> 25) * 32) + int'(i[11:7]);
      "B":      v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      "U":      v = int'(i & 32'hFFFFF000);
      "J":      v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default:  v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic model_hazard();
    byte f;
    logic r1, r2;
    f  = fmt(if1.InstrD);
    r1 = (f == "R" || f == "I" || f == "L" || f == "S" || f == "B") && if1.InstrD[19:15] == m_rd;
    r2 = (f == "R" || f == "S" || f == "B") && if1.InstrD[24:20] == m_rd;
    return if1.ValidD && m_valid && m_isload && m_rd != 0 && (r1 || r2);
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
    return (if1.RegWriteW && if1.RdW != 0 && if1.RdW == src) ? if1.ResultW : rf;
  endfunction

  task automatic m_clear();
    m_valid = 0; m_regwrite = 0; m_isload = 0; m_f7 = 0; m_op = 0; m_f3 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clear();
      m_bubbles = 0;
    end else begin
      logic haz;
      byte  f;
      logic [31:0] i;
      haz = model_hazard();
      i   = if1.InstrD;
      f   = fmt(i);
      if (haz && !if1.FlushE) m_bubbles++;
      if (haz || if1.FlushE) m_clear();
      else begin
        m_valid    = if1.ValidD;
        m_regwrite = if1.ValidD && i[11:7] != 0 && (f == "R" || f == "I" || f == "L" || f == "U" || f == "J");
        m_isload   = if1.ValidD && f == "L";
        m_op = i[6:0]; m_f3 = i[14:12]; m_f7 = i[30];
        m_rs1 = i[19:15]; m_rs2 = i[24:20]; m_rd = i[11:7];
        m_rd1 = fwd(i[19:15], if1.RD1D);
        m_rd2 = fwd(i[24:20], if1.RD2D);
        m_imm = model_imm(i);
        m_pc = if1.PCD; m_pc4 = if1.PCPlus4D;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",   {31'd0, if1.StallD},    {31'd0, model_hazard() && !if1.FlushE});
      check("valid",   {31'd0, if1.ValidE},    {31'd0, m_valid});
      check("regwr",   {31'd0, if1.RegWriteE}, {31'd0, m_regwrite});
      check("isload",  {31'd0, if1.IsLoadE},   {31'd0, m_isload});
      check("fields",  {9'd0, if1.OpcodeE, if1.Funct3E, if1.Funct7b5E, if1.Rs1E, if1.Rs2E, if1.RdE},
                       {9'd0, m_op, m_f3, m_f7, m_rs1, m_rs2, m_rd});
      check("rd1",     if1.RD1E,     m_rd1);
      check("rd2",     if1.RD2E,     m_rd2);
      check("imm",     if1.ImmExtE,  m_imm);
      check("pc",      if1.PCE,      m_pc);
      check("pc4",     if1.PCPlus4E, m_pc4);
      check("cnt16",   {16'd0, if1.BubbleCnt}, (m_bubbles > 65535) ? 32'd65535 : 32'(m_bubbles));
      check("cnt2",    {30'd0, if2.BubbleCnt}, (m_bubbles > 3) ? 32'd3 : 32'(m_bubbles));
      check("stall2",  {31'd0, if2.StallD}, {31'd0, if1.StallD});
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc;

  task automatic drive(input logic [31:0] instr, input logic v, input logic [31:0] a, input logic [31:0] b);
    if1.InstrD = instr; if1.ValidD = v; if1.RD1D = a; if1.RD2D = b;
    if1.PCD = pc; if1.PCPlus4D = pc + 32'd4;
    pc = pc + 32'd4;
  endtask

  task automatic wb(input logic w, input logic [4:0] r, input logic [31:0] d);
    if1.RegWriteW = w; if1.RdW = r; if1.ResultW = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] ADD_X6 = 32'h00028333;

  logic [31:0] traffic [6];

  initial begin
    total = 0; bad = 0; chk_en = 0; pc = 32'h100;
    traffic[0] = 32'h123453B7;  // lui x7,0x12345
    traffic[1] = 32'h010000EF;  // jal x1,16
    traffic[2] = 32'hFE208CE3;  // beq x1,x2,-8
    traffic[3] = 32'h00001197;  // auipc x3,1
    traffic[4] = 32'h00008067;  // jalr x0,0(x1)
    traffic[5] = 32'h40B50533;  // sub x10,x10,x11

    rst = 1'b1; if1.FlushE = 0; wb(0, 0, 0); drive(32'h0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("rst0_valid", {31'd0, if1.ValidE}, 32'd0);
    check("rst0_cnt",   {16'd0, if1.BubbleCnt}, 32'd0);
    check("rst0_pc",    if1.PCE, 32'd0);
    tick(); tick();
    rst = 1'b1; chk_en = 1;

    // immediates
    drive(32'hFFF00293, 1, 32'h0, 32'h0); tick();
    check("t2_rd",    {27'd0, if1.RdE}, 32'd5);
    check("t2_imm",   if1.ImmExtE, 32'hFFFFFFFF);
    check("t2_regwr", {31'd0, if1.RegWriteE}, 32'd1);
    drive(32'h0020A423, 1, 32'h11, 32'h22); tick();
    check("t2s_imm",   if1.ImmExtE, 32'd8);
    check("t2s_regwr", {31'd0, if1.RegWriteE}, 32'd0);

    // bypass
    drive(32'h00528333, 1, 32'h0, 32'h0); wb(1, 5, 32'h1234); tick();
    check("t3_rd1", if1.RD1E, 32'h1234);
    check("t3_rd2", if1.RD2E, 32'h1234);
    drive(32'h00528333, 1, 32'h0, 32'h0); wb(1, 0, 32'h1234); tick();
    check("t3z_rd1", if1.RD1E, 32'h0);
    check("t3z_rd2", if1.RD2E, 32'h0);
    wb(0, 0, 0);

    // load-use
    drive(LW_X5, 1, 32'h40, 32'h0); tick();
    drive(ADD_X6, 1, 32'h0, 32'h0); #1;
    check("t4_stall", {31'd0, if1.StallD}, 32'd1);
    tick();
    check("t4_bubble", {31'd0, if1.ValidE}, 32'd0);
    check("t4_stall1", {31'd0, if1.StallD}, 32'd0);
    check("t4_cnt",    {16'd0, if1.BubbleCnt}, 32'd1);
    tick();
    check("t4_add_v",  {31'd0, if1.ValidE}, 32'd1);
    check("t4_add_rd", {27'd0, if1.RdE}, 32'd6);

    // flush beats hazard
    drive(LW_X5, 1, 32'h40, 32'h0); tick();
    drive(ADD_X6, 1, 32'h0, 32'h0); if1.FlushE = 1; #1;
    check("t5_stall", {31'd0, if1.StallD}, 32'd0);
    tick();
    if1.FlushE = 0;
    check("t5_valid", {31'd0, if1.ValidE}, 32'd0);
    check("t5_cnt",   {16'd0, if1.BubbleCnt}, 32'd1);

    for (int k = 0; k < 6; k++) begin
      drive(traffic[k], 1, 32'hA0 + 32'(k), 32'hB0 + 32'(k));
      wb(k[0], 5'd10, 32'hCAFE0000 + 32'(k));
      tick();
      if (k == 0) check("lui_imm", if1.ImmExtE, 32'h12345000);
      if (k == 1) check("jal_imm", if1.ImmExtE, 32'd16);
    end
    wb(0, 0, 0);

    // asynchronous reset with a pending hazard
    drive(LW_X5, 1, 32'h40, 32'h0); tick();
    drive(ADD_X6, 1, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("t1_valid", {31'd0, if1.ValidE}, 32'd0);
    check("t1_load",  {31'd0, if1.IsLoadE}, 32'd0);
    check("t1_rd",    {27'd0, if1.RdE}, 32'd0);
    check("t1_pc",    if1.PCE, 32'd0);
    check("t1_cnt",   {16'd0, if1.BubbleCnt}, 32'd0);
    check("t1_stall", {31'd0, if1.StallD}, 32'd0);
    tick();
    rst = 1'b1;

    // saturation of the narrow counter
    for (int k = 0; k < 5; k++) begin
      drive(LW_X5, 1, 32'h40, 32'h0); tick();
      drive(ADD_X6, 1, 32'h0, 32'h0); tick(); tick();
    end
    check("t6_cnt2",  {30'd0, if2.BubbleCnt}, 32'd3);
    check("t6_cnt16", {16'd0, if1.BubbleCnt}, 32'd5);
    drive(32'h0, 0, 0, 0); tick(); tick();
    check("t6_hold2", {30'd0, if2.BubbleCnt}, 32'd3);

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
